deser_frame_ctrl: RTL and testbench
===================================

// Module: deser_frame_ctrl
// PURPOSE
//  Frame sequencer for the multi-bit deserializer. Hunts a sync word on the incoming word stream, then drives the deserializer enable for FRAME_BEATS groups of PARL_WIDTH words.
//  Captures each completed parallel group into a 1-entry output buffer with a valid/ready handshake and tags the last group of each frame.
//  Sits between the lane receiver and the downstream packet consumer.
// PARAMETERS
//  DATA_WIDTH   8      bits per serial word
//  PARL_WIDTH   8      words per parallel group (deserializer depth), >=2
//  FRAME_BEATS  4      groups per frame, >=1
//  SYNC_WORD    8'hA5  frame-start marker, DATA_WIDTH bits
// PORTS
//  clk        in   1                      clock
//  rst_n      in   1                      reset, asynchronous, active-low
//  arm        in   1                      level; high = accept frames back-to-back
//  cfg_dir    in   1                      parallel direction, sampled at IDLE->HUNT
//  in_vld     in   1                      serial word valid
//  in_dat     in   DATA_WIDTH             serial word
//  des_en     out  1                      to deserializer en
//  des_dir    out  1                      to deserializer dir
//  des_valid  in   1                      from deserializer valid
//  des_par    in   DATA_WIDTH*PARL_WIDTH  flattened deserializer par; word i at [i*DW +: DW]
//  out_vld    out  1                      output group valid
//  out_rdy    in   1                      downstream ready
//  out_dat    out  DATA_WIDTH*PARL_WIDTH  held group
//  out_last   out  1                      group is last of frame
//  busy       out  1                      state != IDLE
//  err_gap    out  1                      sticky: in_vld dropped mid-group
//  err_ovf    out  1                      sticky: group lost, buffer full
//  frame_cnt  out  16                     frames delivered, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, out_dat 0, sticky flags 0, frame_cnt 0.
//  FSM IDLE->HUNT: arm=1. Latch des_dir<=cfg_dir.
//  FSM HUNT->RUN: in_vld && in_dat==SYNC_WORD. Sync word is consumed and never passed to the deserializer.
//  HUNT->IDLE: arm=0.
//  FSM RUN: des_en = in_vld (combinational).
//   - word_cnt counts 0..PARL_WIDTH-1 per group; beat_cnt counts 0..FRAME_BEATS-1 per frame.
//   - After the FRAME_BEATS*PARL_WIDTH-th word: go to HUNT if arm=1, else IDLE.
//  Gaps: a gap is allowed only when word_cnt==0. A gap elsewhere (the deserializer counter would reset) sets err_gap, clears the counters, and aborts to HUNT (IDLE if arm=0). The partial group is discarded.
//  Capture: des_valid is sampled in every state, because the last group's valid arrives 1 cycle after the last word.
//   - If the buffer is empty, or out_rdy is high in the same cycle: out_dat<=des_par, out_vld<=1, out_last<=(group was beat FRAME_BEATS-1).
//   - Otherwise: drop the group, set err_ovf, and keep the existing entry.
//  The capture tag uses a per-group beat value registered alongside des_en, not the live beat_cnt.
//  Handshake: transfer when out_vld && out_rdy. out_vld clears next cycle unless a capture happens in the same cycle. out_dat is stable while out_vld && !out_rdy.
//  frame_cnt increments on transfer with out_last=1. Aborted frames are never counted.
//  Latency: last word of a group on cycle N -> des_valid N+1 -> out_vld N+2.
//  Sticky flags clear only on reset. arm=0 mid-RUN finishes the current frame.
//  Reset asserted mid-frame: immediate return to reset state; the buffered group is lost.
// STRUCTURE
//  Package deser_pkg: typedef enum logic [1:0] {IDLE,HUNT,RUN} deser_st_e; localparam FRAME_CNT_W=16.
//  Sub-module deser_out_buf: 1-entry valid/ready holding register with data+last and overflow flag.
//  Counters and FSM live in the top module.
// TESTING
//  1. arm=1, A5 then 32 contiguous words 0..31 (dir=0), out_rdy=1 -> 4 groups; group3 out_last=1; frame_cnt=1.
//  2. Same stream, out_rdy=0 -> group0 held stable; groups1-3 dropped; err_ovf=1; out_rdy=1 -> frame_cnt stays 0.
//  3. 1-cycle in_vld gap after word 3 of group 1 -> err_gap=1, back to HUNT; next A5+32 words -> frame_cnt=1.
//  4. Gap at a group boundary -> no error; 4 groups delivered.
//  5. arm dropped during beat 2 -> frame completes, busy=0 two cycles after the last word.
//  6. rst_n low mid-group 2 -> out_vld=0, frame_cnt=0, state IDLE. Words 0x55 without A5 -> des_en never 1.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and constants for the deserializer frame sequencer.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        RUN  = 2'd2
    } deser_st_e;

    localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register for completed parallel groups.
// A group arriving while the entry is occupied and not draining is dropped.
module deser_out_buf #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_en,
    input  logic [WIDTH-1:0] cap_dat,
    input  logic             cap_last,
    input  logic             out_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    output logic             out_last,
    output logic             err_ovf,
    output logic             xfer
);

    logic can_load;

    always_comb begin
        xfer     = out_vld && out_rdy;
        can_load = !out_vld || out_rdy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_last <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            if (cap_en && can_load) begin
                out_vld  <= 1'b1;
                out_dat  <= cap_dat;
                out_last <= cap_last;
            end else begin
                if (cap_en) begin
                    err_ovf <= 1'b1;
                end
                if (xfer) begin
                    out_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/deser_frame_ctrl.sv
// Frame sequencer: hunts the sync word, enables the deserializer for a full
// frame of groups, and buffers each completed group for the downstream consumer.
module deser_frame_ctrl
    import deser_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           PARL_WIDTH  = 8,
    parameter int unsigned           FRAME_BEATS = 4,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = 8'hA5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             arm,
    input  logic                             cfg_dir,
    input  logic                             in_vld,
    input  logic [DATA_WIDTH-1:0]            in_dat,
    output logic                             des_en,
    output logic                             des_dir,
    input  logic                             des_valid,
    input  logic [DATA_WIDTH*PARL_WIDTH-1:0] des_par,
    output logic                             out_vld,
    input  logic                             out_rdy,
    output logic [DATA_WIDTH*PARL_WIDTH-1:0] out_dat,
    output logic                             out_last,
    output logic                             busy,
    output logic                             err_gap,
    output logic                             err_ovf,
    output logic [FRAME_CNT_W-1:0]           frame_cnt
);

    localparam int unsigned WCW = $clog2(PARL_WIDTH);
    localparam int unsigned BCW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [WCW-1:0] WORD_LAST = WCW'(PARL_WIDTH - 1);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(FRAME_BEATS - 1);

    deser_st_e      state;
    deser_st_e      state_nxt;
    logic [WCW-1:0] word_cnt;
    logic [BCW-1:0] beat_cnt;
    logic           word_end;
    logic           frame_end;
    logic           gap_hit;
    logic           grp_last;
    logic           xfer;

    always_comb begin
        word_end  = (state == RUN) && in_vld && (word_cnt == WORD_LAST);
        frame_end = word_end && (beat_cnt == BEAT_LAST);
        gap_hit   = (state == RUN) && !in_vld && (word_cnt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (arm) state_nxt = HUNT;
            HUNT: begin
                if (!arm) begin
                    state_nxt = IDLE;
                end else if (in_vld && (in_dat == SYNC_WORD)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (frame_end || gap_hit) begin
                    state_nxt = arm ? HUNT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        des_en = (state == RUN) && in_vld;
        busy   = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            beat_cnt <= '0;
        end else if ((state != RUN) || gap_hit) begin
            word_cnt <= '0;
            beat_cnt <= '0;
        end else if (in_vld) begin
            if (word_end) begin
                word_cnt <= '0;
                beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // beat_cnt has already moved on when des_valid arrives, so the
    // last-of-frame tag is registered with every enabled word instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_last <= 1'b0;
        end else if (des_en) begin
            grp_last <= (beat_cnt == BEAT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            des_dir   <= 1'b0;
            err_gap   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if ((state == IDLE) && arm) begin
                des_dir <= cfg_dir;
            end
            if (gap_hit) begin
                err_gap <= 1'b1;
            end
            if (xfer && out_last) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    deser_out_buf #(
        .WIDTH(DATA_WIDTH * PARL_WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap_en   (des_valid),
        .cap_dat  (des_par),
        .cap_last (grp_last),
        .out_rdy  (out_rdy),
        .out_vld  (out_vld),
        .out_dat  (out_dat),
        .out_last (out_last),
        .err_ovf  (err_ovf),
        .xfer     (xfer)
    );

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// Directed bench for deser_frame_ctrl with a behavioural deserializer and
// a scoreboard of expected delivered groups.
module tb_deser_frame_ctrl;

    localparam int DW = 8;
    localparam int PW = 8;
    localparam int FB = 4;
    localparam int GW = DW * PW;

    typedef struct {
        logic [GW-1:0] dat;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm;
    logic          cfg_dir;
    logic          in_vld;
    logic [DW-1:0] in_dat;
    logic          des_en;
    logic          des_dir;
    logic          des_valid;
    logic [GW-1:0] des_par;
    logic          out_vld;
    logic          out_rdy;
    logic [GW-1:0] out_dat;
    logic          out_last;
    logic          busy;
    logic          err_gap;
    logic          err_ovf;
    logic [15:0]   frame_cnt;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   en_cnt  = 0;

    // deserializer model state
    int            m_cnt;
    logic [GW-1:0] m_acc;
    logic [GW-1:0] m_tmp;

    always #5 clk = ~clk;

    deser_frame_ctrl #(
        .DATA_WIDTH (DW),
        .PARL_WIDTH (PW),
        .FRAME_BEATS(FB),
        .SYNC_WORD  (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .cfg_dir   (cfg_dir),
        .in_vld    (in_vld),
        .in_dat    (in_dat),
        .des_en    (des_en),
        .des_dir   (des_dir),
        .des_valid (des_valid),
        .des_par   (des_par),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_dat   (out_dat),
        .out_last  (out_last),
        .busy      (busy),
        .err_gap   (err_gap),
        .err_ovf   (err_ovf),
        .frame_cnt (frame_cnt)
    );

    // Deserializer: collects PW enabled words, valid one cycle after the last;
    // dropping en restarts the group.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     <= 0;
            m_acc     <= '0;
            des_valid <= 1'b0;
            des_par   <= '0;
        end else if (des_en) begin
            m_tmp = m_acc;
            m_tmp[(des_dir ? (PW - 1 - m_cnt) : m_cnt) * DW +: DW] = in_dat;
            m_acc <= m_tmp;
            if (m_cnt == PW - 1) begin
                des_valid <= 1'b1;
                des_par   <= m_tmp;
                m_cnt     <= 0;
            end else begin
                des_valid <= 1'b0;
                m_cnt     <= m_cnt + 1;
            end
        end else begin
            des_valid <= 1'b0;
            m_cnt     <= 0;
        end
    end

    function automatic logic [GW-1:0] grp(int g, bit dir);
        logic [GW-1:0] r;
        r = '0;
        for (int j = 0; j < PW; j++) begin
            r[(dir ? (PW - 1 - j) : j) * DW +: DW] = 8'(g * PW + j);
        end
        return r;
    endfunction

    task automatic push_grp(int g, bit dir);
        exp_t e;
        e.dat  = grp(g, dir);
        e.last = (g == FB - 1);
        q.push_back(e);
    endtask

    task automatic chk(string tag, logic [GW-1:0] obs, logic [GW-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check any handshake at the negedge, step past posedge.
    task automatic send(bit v, logic [DW-1:0] d);
        exp_t e;
        in_vld = v;
        in_dat = d;
        @(negedge clk);
        if (des_en) en_cnt++;
        if (rst_n && out_vld && out_rdy) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_xfer: observed data %0h expected none", out_dat);
            end else begin
                e = q.pop_front();
                chk("xfer_dat", out_dat, e.dat);
                chk("xfer_last", GW'(out_last), GW'(e.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) send(1'b0, '0);
    endtask

    task automatic send_words(int lo, int hi);
        for (int k = lo; k <= hi; k++) send(1'b1, 8'(k));
    endtask

    task automatic send_frame();
        send(1'b1, 8'hA5);
        send_words(0, PW * FB - 1);
    endtask

    task automatic drain(string tag);
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            idle(1);
            k++;
        end
        chk(tag, GW'(q.size()), '0);
        idle(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        arm   = 1'b0;
        idle(2);
        q.delete();
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        int en_snap;
        rst_n   = 1'b0;
        arm     = 1'b0;
        cfg_dir = 1'b0;
        in_vld  = 1'b0;
        in_dat  = '0;
        out_rdy = 1'b1;
        #1;
        chk("rst_out_vld", GW'(out_vld), '0);
        chk("rst_out_dat", out_dat, '0);
        chk("rst_frame_cnt", GW'(frame_cnt), '0);
        chk("rst_busy", GW'(busy), '0);
        chk("rst_errs", GW'({err_gap, err_ovf, des_en, out_last}), '0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // 1: one full frame, consumer always ready
        arm = 1'b1;
        idle(1);
        chk("t1_busy", GW'(busy), GW'(1));
        chk("t1_dir", GW'(des_dir), '0);
        for (int g = 0; g < FB; g++) push_grp(g, 1'b0);
        send_frame();
        drain("t1_drain");
        chk("t1_frame_cnt", GW'(frame_cnt), GW'(1));
        chk("t1_errs", GW'({err_gap, err_ovf}), '0);

        // 2: consumer stalled, later groups overflow
        do_reset();
        arm     = 1'b1;
        out_rdy = 1'b0;
        idle(1);
        push_grp(0, 1'b0);
        send_frame();
        idle(4);
        chk("t2_hold_vld", GW'(out_vld), GW'(1));
        chk("t2_hold_dat", out_dat, grp(0, 1'b0));
        chk("t2_hold_last", GW'(out_last), '0);
        chk("t2_ovf", GW'(err_ovf), GW'(1));
        out_rdy = 1'b1;
        drain("t2_drain");
        chk("t2_frame_cnt", GW'(frame_cnt), '0);

        // 3: gap mid-group aborts the frame
        do_reset();
        arm = 1'b1;
        idle(1);
        push_grp(0, 1'b0);
        send(1'b1, 8'hA5);
        send_words(0, PW + 3);
        idle(1);
        chk("t3_err_gap", GW'(err_gap), GW'(1));
        chk("t3_busy_hunt", GW'(busy), GW'(1));
        for (int g = 0; g < FB; g++) push_grp(g, 1'b0);
        send_frame();
        drain("t3_drain");
        chk("t3_frame_cnt", GW'(frame_cnt), GW'(1));

        // 4: gap on a group boundary, reversed direction
        do_reset();
        cfg_dir = 1'b1;
        arm     = 1'b1;
        idle(1);
        chk("t4_dir", GW'(des_dir), GW'(1));
        for (int g = 0; g < FB; g++) push_grp(g, 1'b1);
        send(1'b1, 8'hA5);
        send_words(0, 2 * PW - 1);
        idle(2);
        send_words(2 * PW, PW * FB - 1);
        drain("t4_drain");
        chk("t4_err_gap", GW'(err_gap), '0);
        chk("t4_frame_cnt", GW'(frame_cnt), GW'(1));
        cfg_dir = 1'b0;

        // 5: disarm during beat 2 lets the frame finish
        do_reset();
        arm = 1'b1;
        idle(1);
        for (int g = 0; g < FB; g++) push_grp(g, 1'b0);
        send(1'b1, 8'hA5);
        send_words(0, 2 * PW);
        arm = 1'b0;
        send_words(2 * PW + 1, PW * FB - 2);
        chk("t5_busy_mid", GW'(busy), GW'(1));
        send_words(PW * FB - 1, PW * FB - 1);
        idle(1);
        chk("t5_busy_end", GW'(busy), '0);
        drain("t5_drain");
        chk("t5_frame_cnt", GW'(frame_cnt), GW'(1));
        chk("t5_stay_idle", GW'(busy), '0);

        // 6: asynchronous reset mid-frame, then no sync word
        do_reset();
        arm = 1'b1;
        idle(1);
        push_grp(0, 1'b0);
        push_grp(1, 1'b0);
        send(1'b1, 8'hA5);
        send_words(0, 2 * PW + 3);
        chk("t6_q_pre", GW'(q.size()), '0);
        rst_n = 1'b0;
        #1;
        chk("t6_out_vld", GW'(out_vld), '0);
        chk("t6_frame_cnt", GW'(frame_cnt), '0);
        chk("t6_busy", GW'(busy), '0);
        idle(2);
        q.delete();
        rst_n   = 1'b1;
        en_snap = en_cnt;
        for (int k = 0; k < 20; k++) send(1'b1, 8'h55);
        chk("t6_no_en", GW'(en_cnt - en_snap), '0);
        chk("t6_hunting", GW'(busy), GW'(1));
        chk("t6_no_out", GW'(out_vld), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
